ap_ctrl_sequencer: RTL and testbench
====================================

// Module: ap_ctrl_sequencer
// PURPOSE
//  Synthesizable initiator side of the ap_ctrl_chain block-level handshake (ap_start/ap_ready/ap_done/ap_continue).
//  Launches up to NUM_STAGES HLS kernels (e.g. vector_scale, vector_subtract, vector_add, vector_add2) strictly
//  one after another, in index order, skipping stages whose mask bit is 0. Sits between the top-level control
//  and the kernel ap_ctrl ports; produces the waveforms that dataflow_monitor observes in simulation.
// PARAMETERS
//  NUM_STAGES  4   number of sequenced kernels (1..16)
//  IDX_W       2   width of cur_stage; must be >= clog2(NUM_STAGES), min 1
//  CNT_W       32  width of each perf counter (SEQ_PERF_CNT_EN only)
// PORTS
//  clock              in   1             system clock, all logic on posedge
//  reset              in   1             synchronous, active-high
//  start              in   1             run request, sampled only in IDLE
//  stage_mask         in   NUM_STAGES    bit i=1 -> run stage i; sampled with start
//  busy               out  1             high from cycle after start accepted until done pulse
//  done               out  1             one-cycle pulse, run complete
//  cur_stage          out  IDX_W         index of stage being launched/awaited; 0 when idle
//  stage_ap_start     out  NUM_STAGES    one-hot (or 0) ap_start to kernels
//  stage_ap_ready     in   NUM_STAGES    kernel ap_ready
//  stage_ap_done      in   NUM_STAGES    kernel ap_done (held by kernel until ap_continue)
//  stage_ap_continue  out  NUM_STAGES    one-hot (or 0) ap_continue to kernels
//  perf_cycles        out  NUM_STAGES*CNT_W  per-stage cycle counts, stage i at [i*CNT_W +: CNT_W]
//                                            (SEQ_PERF_CNT_EN only)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, cur_stage, stage_ap_start, stage_ap_continue, perf_cycles all 0.
//   Reset mid-run aborts immediately; no done pulse.
//  FSM states IDLE, SELECT, LAUNCH, WAIT_DONE, FINISH. All outputs are Moore (decoded from registered state/index).
//  IDLE: start=1 -> latch mask, index=0, go SELECT. start while not IDLE is ignored, never queued.
//  SELECT: priority-find the lowest set bit of the latched mask at >= index (combinational, 0 cycles per skip).
//   Found -> cur_stage=that index, go LAUNCH. None -> go FINISH.
//  LAUNCH: stage_ap_start[cur_stage]=1. Held until stage_ap_ready[cur_stage] is sampled 1, then go WAIT_DONE.
//   ap_start deasserts on the cycle after ready is sampled.
//  WAIT_DONE: stage_ap_continue[cur_stage]=1. When stage_ap_done[cur_stage]=1, completion occurs that cycle;
//   clear the mask bit, go SELECT.
//  ready+done in the same LAUNCH cycle: go WAIT_DONE. Continue is low in LAUNCH, so the kernel holds done and
//   completion occurs on the next cycle.
//  done seen in LAUNCH before ready is not acted on (continue low); the kernel holds it.
//  FINISH: done=1 for exactly one cycle, busy=0 the same cycle, cur_stage=0, go IDLE. New start accepted next cycle.
//  ready/done from unselected or non-current stages are ignored.
//  At most one bit of stage_ap_start|stage_ap_continue is high in any cycle.
//  Latency: start at cycle t -> first ap_start at t+2. Empty mask: done at t+2.
//   Minimal stage (ready+done same cycle) costs 3 cycles (SELECT, LAUNCH, WAIT_DONE).
//  No timeout: a hung kernel keeps the FSM in LAUNCH/WAIT_DONE until reset.
// CONFIGURATION
//  SEQ_PERF_CNT_EN defined:
//   - perf_cycles present; all counters cleared on the cycle start is accepted.
//   - counter[cur_stage] increments every cycle in LAUNCH or WAIT_DONE for that stage, saturating at 2^CNT_W-1.
//   - values hold after done until the next accepted start.
//  SEQ_PERF_CNT_EN undefined: perf_cycles port and its counters are absent; all other behaviour is identical.
// TESTING
//  1 reset high 3 cycles mid-LAUNCH -> all outputs 0 on next cycle; no done pulse; FSM returns to IDLE.
//  2 mask=4'b1111, each kernel ready on 1st ap_start cycle, done 5 cycles later -> ap_start pulses stages 0,1,2,3
//    in order, one-hot, never overlapping; one done pulse.
//  3 mask=4'b0101 -> only stages 0 and 2 receive ap_start; stages 1 and 3 outputs stay 0; cur_stage shows 0 then 2.
//  4 mask=0 with start at cycle t -> done=1 at t+2; no ap_start ever asserted.
//  5 stage 1 asserts ready+done together on its first ap_start cycle -> continue[1] is high exactly 1 cycle,
//    on the next cycle; stage 2 ap_start follows 2 cycles later.
//  6 SEQ_PERF_CNT_EN, CNT_W=4, stage 0 takes 20 cycles -> perf_cycles[3:0]=4'hF (saturated);
//    a second start clears it to 0.

Source files
------------

// File: rtl/ap_ctrl_sequencer.sv
// ap_ctrl_sequencer
// Initiator side of the ap_ctrl_chain handshake. Launches up to NUM_STAGES
// HLS kernels one after another in index order, skipping stages whose mask
// bit is clear. All outputs are decoded from registered state (Moore).
// Optional per-stage cycle counters are compiled in when the macro
// SEQ_PERF_CNT_EN is defined.
module ap_ctrl_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int IDX_W      = 2,
    parameter int CNT_W      = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_STAGES-1:0]       stage_mask,
    output logic                        busy,
    output logic                        done,
    output logic [IDX_W-1:0]            cur_stage,
    output logic [NUM_STAGES-1:0]       stage_ap_start,
    input  logic [NUM_STAGES-1:0]       stage_ap_ready,
    input  logic [NUM_STAGES-1:0]       stage_ap_done,
    output logic [NUM_STAGES-1:0]       stage_ap_continue
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [NUM_STAGES*CNT_W-1:0] perf_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LAUNCH,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t                state, stateNext;
    logic [IDX_W-1:0]      idx, idxNext;
    logic [NUM_STAGES-1:0] mask, maskNext;
    logic                  found;
    logic [IDX_W-1:0]      foundIdx;

    // Catch parameter combinations that cannot index every stage
    if (NUM_STAGES < 1 || NUM_STAGES > 16 || IDX_W < 1 || CNT_W < 1 ||
        (1 << IDX_W) < NUM_STAGES) begin : g_bad_params
        $error("ap_ctrl_sequencer: illegal parameter combination");
    end

    // Lowest pending stage at or above the current index, found in zero cycles
    always_comb begin
        found    = 1'b0;
        foundIdx = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(idx))) begin
                found    = 1'b1;
                foundIdx = IDX_W'(i);
            end
        end
    end

    // Next-state, next-index and pending-mask update
    always_comb begin
        stateNext = state;
        idxNext   = idx;
        maskNext  = mask;
        case (state)
            IDLE: begin
                if (start) begin
                    maskNext  = stage_mask;
                    idxNext   = '0;
                    stateNext = SELECT;
                end
            end
            SELECT: begin
                if (found) begin
                    idxNext   = foundIdx;
                    stateNext = LAUNCH;
                end else begin
                    stateNext = FINISH;
                end
            end
            LAUNCH: begin
                if (stage_ap_ready[idx]) begin
                    stateNext = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (stage_ap_done[idx]) begin
                    maskNext[idx] = 1'b0;
                    stateNext     = SELECT;
                end
            end
            FINISH: begin
                idxNext   = '0;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State, index and pending-mask registers; reset aborts any run at once
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            mask  <= '0;
        end else begin
            state <= stateNext;
            idx   <= idxNext;
            mask  <= maskNext;
        end
    end

    // Moore output decode: one-hot start/continue toward the current kernel
    always_comb begin
        busy              = (state == SELECT) || (state == LAUNCH) || (state == WAIT_DONE);
        done              = (state == FINISH);
        cur_stage         = busy ? idx : '0;
        stage_ap_start    = '0;
        stage_ap_continue = '0;
        if (state == LAUNCH) begin
            stage_ap_start[idx] = 1'b1;
        end
        if (state == WAIT_DONE) begin
            stage_ap_continue[idx] = 1'b1;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] curCount;

    assign curCount = perf_cycles[int'(idx)*CNT_W +: CNT_W];

    // Per-stage saturating cycle counters, cleared when a run is accepted
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_cycles <= '0;
        end else if (state == IDLE && start) begin
            perf_cycles <= '0;
        end else if ((state == LAUNCH || state == WAIT_DONE) && curCount != '1) begin
            perf_cycles[int'(idx)*CNT_W +: CNT_W] <= curCount + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// tb_ap_ctrl_sequencer
// Self-checking bench: a behavioural kernel model answers ap_start/ap_continue,
// expected launch order and done pulses are queued when a run is started and
// popped as the sequencer produces them. Counter checks need SEQ_PERF_CNT_EN.
module tb_ap_ctrl_sequencer;

    localparam int NS = 4;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [NS-1:0] stage_mask = '0;
    logic          busy;
    logic          done;
    logic [1:0]    cur_stage;
    logic [NS-1:0] stage_ap_start;
    logic [NS-1:0] stage_ap_continue;
    logic [NS-1:0] kReady = '0;
    logic [NS-1:0] kDone  = '0;
`ifdef SEQ_PERF_CNT_EN
    logic [NS*CW-1:0] perf_cycles;
`endif

    int checks = 0;
    int errors = 0;

    int expLaunch[$];
    int expDone[$];

    int rdyDly[NS];
    int doneDly[NS];
    int kst[NS];
    int rdyWait[NS];
    int dcnt[NS];
    logic kernelClear = 1'b0;

    int launchCyc[NS];
    int contFirst[NS];
    int contCnt[NS];
    int firstLaunchCyc;
    int doneCyc;
    logic [NS-1:0] seen;

    ap_ctrl_sequencer #(
        .NUM_STAGES(NS),
        .IDX_W     (2),
        .CNT_W     (CW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .stage_mask       (stage_mask),
        .busy             (busy),
        .done             (done),
        .cur_stage        (cur_stage),
        .stage_ap_start   (stage_ap_start),
        .stage_ap_ready   (kReady),
        .stage_ap_done    (kDone),
        .stage_ap_continue(stage_ap_continue)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_cycles      (perf_cycles)
`endif
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Kernel model: ready after rdyDly launch cycles, done doneDly cycles later, held until continue
    always @(negedge clock) begin
        for (int i = 0; i < NS; i++) begin
            if (reset || kernelClear) begin
                kst[i]     = 0;
                rdyWait[i] = 0;
                dcnt[i]    = 0;
                kReady[i]  = 1'b0;
                kDone[i]   = 1'b0;
            end else begin
                kReady[i] = 1'b0;
                case (kst[i])
                    0: begin
                        if (stage_ap_start[i]) begin
                            if (rdyWait[i] >= rdyDly[i]) begin
                                kReady[i] = 1'b1;
                                dcnt[i]   = 0;
                                if (doneDly[i] == 0) begin
                                    kDone[i] = 1'b1;
                                    kst[i]   = stage_ap_continue[i] ? 3 : 2;
                                end else begin
                                    kst[i] = 1;
                                end
                            end else begin
                                rdyWait[i]++;
                            end
                        end
                    end
                    1: begin
                        dcnt[i]++;
                        if (dcnt[i] >= doneDly[i]) begin
                            kDone[i] = 1'b1;
                            kst[i]   = stage_ap_continue[i] ? 3 : 2;
                        end
                    end
                    2: begin
                        if (stage_ap_continue[i]) kst[i] = 3;
                    end
                    default: begin
                        kDone[i]   = 1'b0;
                        kst[i]     = 0;
                        rdyWait[i] = 0;
                    end
                endcase
            end
        end
    end

    task automatic setKernels(input int rd, input int dd);
        for (int i = 0; i < NS; i++) begin
            rdyDly[i]  = rd;
            doneDly[i] = dd;
        end
        kernelClear = 1'b1;
        @(negedge clock);
        @(negedge clock);
        kernelClear = 1'b0;
    endtask

    task automatic applyStimulus(input logic [NS-1:0] m);
        for (int i = 0; i < NS; i++) begin
            if (m[i]) expLaunch.push_back(i);
        end
        expDone.push_back(1);
        stage_mask = m;
        start      = 1'b1;
    endtask

    task automatic checkOutput(input int budget, input bit poke);
        logic [NS-1:0] prevStart;
        bit finished;
        int cyc;
        int e;
        prevStart      = '0;
        finished       = 1'b0;
        cyc            = 0;
        firstLaunchCyc = -1;
        doneCyc        = -1;
        seen           = '0;
        for (int i = 0; i < NS; i++) begin
            launchCyc[i] = -1;
            contFirst[i] = -1;
            contCnt[i]   = 0;
        end
        while (!finished && cyc < budget) begin
            @(negedge clock);
            cyc++;
            start = poke && (cyc == 3);
            checks++;
            if ($countones(stage_ap_start | stage_ap_continue) > 1) begin
                errors++;
                $display("[TB] FAIL onehot: start=%b continue=%b at cycle %0d", stage_ap_start, stage_ap_continue, cyc);
            end
            seen |= stage_ap_start | stage_ap_continue;
            if (stage_ap_start != '0 && stage_ap_start != prevStart) begin
                checks++;
                if (expLaunch.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL launch_extra: got start=%b, required none", stage_ap_start);
                end else begin
                    e = expLaunch.pop_front();
                    if (stage_ap_start !== NS'(1 << e) || cur_stage !== 2'(e)) begin
                        errors++;
                        $display("[TB] FAIL launch_order: got start=%b cur=%0d, required stage %0d", stage_ap_start, cur_stage, e);
                    end
                    launchCyc[e] = cyc;
                    if (firstLaunchCyc < 0) firstLaunchCyc = cyc;
                end
            end
            for (int i = 0; i < NS; i++) begin
                if (stage_ap_continue[i]) begin
                    if (contFirst[i] < 0) contFirst[i] = cyc;
                    contCnt[i]++;
                end
            end
            checks++;
            if (done) begin
                if (expDone.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL done_extra: got unexpected done at cycle %0d", cyc);
                end else begin
                    void'(expDone.pop_front());
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL busy_at_done: got %b, required 0", busy);
                    end
                end
                doneCyc  = cyc;
                finished = 1'b1;
            end else if (busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL busy_run: got %b, required 1 at cycle %0d", busy, cyc);
            end
            prevStart = stage_ap_start;
        end
        start = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("[TB] FAIL timeout: no done within %0d cycles, required done", budget);
        end
        checks++;
        if (expLaunch.size() != 0) begin
            errors++;
            $display("[TB] FAIL launch_missing: got %0d pending, required 0", expLaunch.size());
        end
        expLaunch.delete();
        expDone.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, done, cur_stage, stage_ap_start, stage_ap_continue} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b, required 0", {busy, done, cur_stage, stage_ap_start, stage_ap_continue});
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_launch;
        bit sawActivity;
        setKernels(100, 1);
        stage_mask = 4'b1111;
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (stage_ap_start !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_launch: got start=%b busy=%b, required 0001 1", stage_ap_start, busy);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({busy, done, cur_stage, stage_ap_start, stage_ap_continue} !== '0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got %b, required 0", {busy, done, cur_stage, stage_ap_start, stage_ap_continue});
        end
`ifdef SEQ_PERF_CNT_EN
        checks++;
        if (perf_cycles !== '0) begin
            errors++;
            $display("[TB] FAIL abort_perf: got %h, required 0", perf_cycles);
        end
`endif
        @(negedge clock);
        @(negedge clock);
        reset       = 1'b0;
        sawActivity = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (done || busy || stage_ap_start != '0 || stage_ap_continue != '0) sawActivity = 1'b1;
        end
        checks++;
        if (sawActivity) begin
            errors++;
            $display("[TB] FAIL abort_idle: got activity after reset, required idle");
        end
    endtask

    task automatic test_all_stages;
        setKernels(0, 5);
        applyStimulus(4'b1111);
        checkOutput(200, 1'b0);
        checks++;
        if (firstLaunchCyc !== 2) begin
            errors++;
            $display("[TB] FAIL first_launch_latency: got %0d, required 2", firstLaunchCyc);
        end
        checks++;
        if (doneCyc !== 30) begin
            errors++;
            $display("[TB] FAIL all_done_cycle: got %0d, required 30", doneCyc);
        end
        for (int i = 0; i < NS; i++) begin
            checks++;
            if (contCnt[i] !== 5) begin
                errors++;
                $display("[TB] FAIL continue_len_%0d: got %0d, required 5", i, contCnt[i]);
            end
        end
    endtask

    task automatic test_sparse_mask;
        setKernels(0, 5);
        applyStimulus(4'b0101);
        checkOutput(200, 1'b0);
        checks++;
        if (seen !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL sparse_seen: got %b, required 0101", seen);
        end
        checks++;
        if (launchCyc[2] !== 9 || doneCyc !== 16) begin
            errors++;
            $display("[TB] FAIL sparse_timing: got launch2=%0d done=%0d, required 9 16", launchCyc[2], doneCyc);
        end
    endtask

    task automatic test_empty_mask;
        setKernels(0, 1);
        applyStimulus(4'b0000);
        checkOutput(20, 1'b0);
        checks++;
        if (doneCyc !== 2 || seen !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL empty_mask: got done=%0d seen=%b, required 2 0000", doneCyc, seen);
        end
    endtask

    task automatic test_ready_done_same_cycle;
        setKernels(0, 2);
        doneDly[1] = 0;
        applyStimulus(4'b1111);
        checkOutput(200, 1'b0);
        checks++;
        if (contCnt[1] !== 1) begin
            errors++;
            $display("[TB] FAIL same_cycle_continue_len: got %0d, required 1", contCnt[1]);
        end
        checks++;
        if (contFirst[1] !== launchCyc[1] + 1 || launchCyc[2] !== contFirst[1] + 2) begin
            errors++;
            $display("[TB] FAIL same_cycle_timing: got launch1=%0d cont1=%0d launch2=%0d, required L L+1 L+3",
                     launchCyc[1], contFirst[1], launchCyc[2]);
        end
        checks++;
        if (launchCyc[1] !== 6) begin
            errors++;
            $display("[TB] FAIL same_cycle_launch1: got %0d, required 6", launchCyc[1]);
        end
    endtask

    task automatic test_back_to_back;
        setKernels(1, 1);
        applyStimulus(4'b0001);
        checkOutput(50, 1'b1);
        checks++;
        if (doneCyc !== 6) begin
            errors++;
            $display("[TB] FAIL b2b_first_done: got %0d, required 6", doneCyc);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_no_queue: got busy=%b done=%b, required 0 0", busy, done);
        end
        applyStimulus(4'b1000);
        checkOutput(50, 1'b0);
        checks++;
        if (launchCyc[3] !== 2 || doneCyc !== 6) begin
            errors++;
            $display("[TB] FAIL b2b_second: got launch3=%0d done=%0d, required 2 6", launchCyc[3], doneCyc);
        end
    endtask

`ifdef SEQ_PERF_CNT_EN
    task automatic test_perf_counters;
        setKernels(0, 3);
        rdyDly[0]  = 10;
        doneDly[0] = 10;
        applyStimulus(4'b0001);
        checkOutput(100, 1'b0);
        checks++;
        if (perf_cycles[3:0] !== 4'hF || perf_cycles[15:4] !== '0) begin
            errors++;
            $display("[TB] FAIL perf_saturate: got %h, required 000F", perf_cycles);
        end
        applyStimulus(4'b0010);
        checkOutput(100, 1'b0);
        @(negedge clock);
        checks++;
        if (perf_cycles[3:0] !== 4'h0 || perf_cycles[7:4] !== 4'h4) begin
            errors++;
            $display("[TB] FAIL perf_clear: got %h, required 0040", perf_cycles);
        end
    endtask
`endif

    // Test sequence
    initial begin
        setKernels(0, 1);
        test_reset;
        test_reset_mid_launch;
        test_all_stages;
        test_sparse_mask;
        test_empty_mask;
        test_ready_done_same_cycle;
        test_back_to_back;
`ifdef SEQ_PERF_CNT_EN
        test_perf_counters;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
